// File: rtl/pipeline_credit_fifo_if.sv
// Handshake bundle for pipeline_credit_fifo: issue credit port, pipeline result strobe, ready/valid output.
interface pipeline_credit_fifo_if #(
  parameter int DATA_W = 32
);
  logic              issue_valid;
  logic              issue_ready;
  logic              pipe_valid;
  logic [DATA_W-1:0] pipe_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (
    output issue_valid, pipe_valid, pipe_data, out_ready,
    input  issue_ready, out_valid, out_data
  );

  modport slave (
    input  issue_valid, pipe_valid, pipe_data, out_ready,
    output issue_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipeline_credit_fifo.sv
// Credit-gated result FIFO behind a fixed-latency pipeline; optional stall counter
// enabled by defining PIPE_CREDIT_FIFO_STATS_EN.
module pipeline_credit_fifo #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 32,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_credit_fifo_if.slave bus,
  output logic [CNT_W-1:0]     credit_cnt,
  output logic [CNT_W-1:0]     fifo_cnt,
  output logic                 overflow_err
`ifdef PIPE_CREDIT_FIFO_STATS_EN
  ,
  output logic [31:0]          issue_stall_cnt
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  credit_nxt, fifo_nxt;
  logic              issue, pop, full, write, drop;

  assign bus.issue_ready = (credit_cnt != '0);
  assign bus.out_valid   = (fifo_cnt != '0);
  assign bus.out_data    = mem[rd_ptr];

  assign issue = bus.issue_valid && bus.issue_ready;
  assign pop   = bus.out_valid && bus.out_ready;
  assign full  = (fifo_cnt == CNT_W'(DEPTH));
  assign write = bus.pipe_valid && (!full || pop);
  assign drop  = bus.pipe_valid && full && !pop;

  always_comb begin
    credit_nxt = credit_cnt;
    // Returned credits never exceed DEPTH, even if upstream broke the protocol.
    if (pop && !issue && credit_cnt != CNT_W'(DEPTH))
      credit_nxt = credit_cnt + CNT_W'(1);
    else if (issue && !pop)
      credit_nxt = credit_cnt - CNT_W'(1);
  end

  always_comb begin
    fifo_nxt = fifo_cnt;
    if (write && !pop)
      fifo_nxt = fifo_cnt + CNT_W'(1);
    else if (!write && pop)
      fifo_nxt = fifo_cnt - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_cnt   <= CNT_W'(DEPTH);
      fifo_cnt     <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      overflow_err <= 1'b0;
    end else begin
      credit_cnt <= credit_nxt;
      fifo_cnt   <= fifo_nxt;
      if (write)
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      if (drop)
        overflow_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (write)
      mem[wr_ptr] <= bus.pipe_data;
  end

`ifdef PIPE_CREDIT_FIFO_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      issue_stall_cnt <= '0;
    else if (bus.issue_valid && !bus.issue_ready && issue_stall_cnt != '1)
      issue_stall_cnt <= issue_stall_cnt + 32'd1;
  end
`endif

endmodule
